// File: rtl/inception_b_sched_if.sv
// Scheduler-facing bundle: controller handshake, kernel memory port, kernel bus,
// upstream pixel stream and datapath stream. Names are from the scheduler's view.
interface inception_b_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KNUM       = 17,
  parameter int AW         = 16
);
  logic                         i_start;
  logic [15:0]                  i_num_pass;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_err;
  logic [15:0]                  o_pass_idx;

  logic                         o_k_rd;
  logic [AW-1:0]                o_k_addr;
  logic [DATA_WIDTH-1:0]        i_k_data;
  logic [KNUM*DATA_WIDTH-1:0]   o_kernel_bus;

  logic                         i_src_valid;
  logic [DATA_WIDTH-1:0]        i_src_data;
  logic                         o_src_ready;

  logic                         o_dp_valid_in;
  logic [DATA_WIDTH-1:0]        o_dp_pxl_in;
  logic                         i_dp_valid_out;

  modport slave (
    input  i_start, i_num_pass, i_k_data, i_src_valid, i_src_data, i_dp_valid_out,
    output o_busy, o_done, o_err, o_pass_idx, o_k_rd, o_k_addr, o_kernel_bus,
           o_src_ready, o_dp_valid_in, o_dp_pxl_in
  );

  modport master (
    output i_start, i_num_pass, i_k_data, i_src_valid, i_src_data, i_dp_valid_out,
    input  o_busy, o_done, o_err, o_pass_idx, o_k_rd, o_k_addr, o_kernel_bus,
           o_src_ready, o_dp_valid_in, o_dp_pxl_in
  );
endinterface

// File: rtl/inception_b_sched.sv
// Pass scheduler for the Inception-ResNet-B datapath: per pass, load a kernel set,
// stream NPIX pixels into the datapath, then wait for NPIX results.

// One kernel word register; written only while its slot is being captured.
module inception_b_kword #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module inception_b_sched #(
  parameter int IMG_SIZE   = 17,
  parameter int DATA_WIDTH = 32,
  parameter int KNUM       = 17,
  parameter int AW         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  inception_b_sched_if.slave  bus
);
  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int WW   = $clog2(KNUM + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            r_state;
  logic [15:0]           r_num_pass;
  logic [15:0]           r_pass_idx;
  logic [WW-1:0]         r_w;
  logic [CW-1:0]         r_in_cnt;
  logic [CW-1:0]         r_out_cnt;
  logic                  r_err;
  logic                  r_dvi;
  logic [DATA_WIDTH-1:0] r_pxl;

  logic                  w_idle, w_load, w_stream, w_drain, w_done;
  logic                  w_k_rd;
  logic                  w_src_fire;
  logic                  w_out_full;
  logic                  w_out_reach;
  logic                  w_cnt_out;
  logic                  w_err_set;
  logic                  w_last_pass;
  logic [AW-1:0]         w_k_addr;
  logic [KNUM-1:0][DATA_WIDTH-1:0] w_kwords;

  assign w_idle   = (r_state == S_IDLE);
  assign w_load   = (r_state == S_LOAD);
  assign w_stream = (r_state == S_STREAM);
  assign w_drain  = (r_state == S_DRAIN);
  assign w_done   = (r_state == S_DONE);

  assign w_k_rd      = w_load && (r_w < WW'(KNUM));
  assign w_k_addr    = AW'(32'(r_pass_idx) * KNUM + 32'(r_w));
  assign w_src_fire  = w_stream && bus.i_src_valid;
  assign w_out_full  = (r_out_cnt == CW'(NPIX));
  // Reached either already or by this cycle's result pulse.
  assign w_out_reach = w_out_full || (bus.i_dp_valid_out && (r_out_cnt == CW'(NPIX - 1)));
  assign w_cnt_out   = (w_stream || w_drain) && bus.i_dp_valid_out && !w_out_full;
  assign w_err_set   = bus.i_dp_valid_out && (w_idle || w_load || w_done || w_out_full);
  assign w_last_pass = (r_pass_idx == (r_num_pass - 16'd1));

  // Word w-1 lands on LOAD cycle w, one cycle behind its read strobe.
  for (genvar gi = 0; gi < KNUM; gi++) begin : g_kw
    inception_b_kword #(.DW(DATA_WIDTH)) u_kw (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_load && (r_w == WW'(gi + 1))),
      .i_d   (bus.i_k_data),
      .o_q   (w_kwords[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_num_pass <= '0;
      r_pass_idx <= '0;
      r_w        <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_err      <= 1'b0;
      r_dvi      <= 1'b0;
      r_pxl      <= '0;
    end else begin
      r_dvi <= 1'b0;
      if (w_cnt_out) r_out_cnt <= r_out_cnt + CW'(1);
      if (w_err_set) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_err <= w_err_set;
            if (bus.i_num_pass != 16'd0) begin
              r_num_pass <= bus.i_num_pass;
              r_pass_idx <= '0;
              r_w        <= '0;
              r_state    <= S_LOAD;
            end else begin
              r_state    <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          r_w <= r_w + WW'(1);
          if (r_w == WW'(KNUM)) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_src_fire) begin
            r_pxl    <= bus.i_src_data;
            r_dvi    <= 1'b1;
            r_in_cnt <= r_in_cnt + CW'(1);
            if (r_in_cnt == CW'(NPIX - 1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_reach) begin
            if (w_last_pass) begin
              r_state <= S_DONE;
            end else begin
              r_pass_idx <= r_pass_idx + 16'd1;
              r_w        <= '0;
              r_state    <= S_LOAD;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy        = !w_idle && !w_done;
  assign bus.o_done        = w_done;
  assign bus.o_err         = r_err;
  assign bus.o_pass_idx    = r_pass_idx;
  assign bus.o_k_rd        = w_k_rd;
  assign bus.o_k_addr      = w_k_rd ? w_k_addr : '0;
  assign bus.o_kernel_bus  = w_kwords;
  assign bus.o_src_ready   = w_stream;
  assign bus.o_dp_valid_in = r_dvi;
  assign bus.o_dp_pxl_in   = r_pxl;
endmodule

// File: tb/tb_inception_b_sched.sv
// Directed bench for inception_b_sched: kernel memory and fixed-latency datapath
// models, pixel scoreboard, and checks of addresses, counts, kernel words and err.
module tb_inception_b_sched;
  localparam int KNUM = 17;
  localparam int DW   = 32;
  localparam int NPIX = 289;
  localparam int KB   = KNUM * DW;
  localparam int LAT  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inception_b_sched_if #(.DATA_WIDTH(DW), .KNUM(KNUM), .AW(16)) bus();

  inception_b_sched #(.IMG_SIZE(17), .DATA_WIDTH(DW), .KNUM(KNUM), .AW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // kernel memory: registered read, data valid the cycle after k_rd
  always @(posedge clk)
    if (bus.o_k_rd) bus.i_k_data <= 32'h1000 + 32'(bus.o_k_addr);

  // datapath model: fixed latency valid pipe, plus an injection point
  logic [LAT-1:0] dl;
  logic inj = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) dl <= '0;
    else        dl <= {dl[LAT-2:0], bus.o_dp_valid_in};
  assign bus.i_dp_valid_out = dl[LAT-1] | inj;

  int total = 0;
  int bad   = 0;
  int n_krd, n_dvi, n_acc, n_done;
  int exp_kaddr;
  int src_mode;
  bit phase;
  bit saw_busy;
  logic [DW-1:0] sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_k(input string tag, input logic [KB-1:0] got, input logic [KB-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [KB-1:0] kexp(input int p);
    logic [KB-1:0] v;
    for (int i = 0; i < KNUM; i++) v[i*DW +: DW] = 32'h1000 + 32'(17 * p + i);
    return v;
  endfunction

  task automatic clr_counts();
    n_krd = 0; n_dvi = 0; n_acc = 0; n_done = 0; exp_kaddr = 0; saw_busy = 0;
    sbq.delete();
  endtask

  // one cycle: monitor outputs at negedge, then drive next-cycle inputs
  task automatic tick();
    @(negedge clk);
    if (bus.o_busy) saw_busy = 1;
    if (bus.o_done) n_done++;
    if (bus.o_k_rd) begin
      chk("k_addr", 32'(bus.o_k_addr), 32'(exp_kaddr));
      exp_kaddr++;
      n_krd++;
    end
    if (bus.o_dp_valid_in) begin
      n_dvi++;
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("dp_pxl", bus.o_dp_pxl_in, sbq.pop_front());
      if ((n_dvi % NPIX) == 1 || (n_dvi % NPIX) == 0)
        chk_k("kernel_stable", bus.o_kernel_bus, kexp((n_dvi - 1) / NPIX));
    end
    phase = ~phase;
    bus.i_src_valid = (src_mode == 1) || (src_mode == 2 && phase);
    bus.i_src_data  = $urandom;
    if (bus.i_src_valid && bus.o_src_ready) begin
      sbq.push_back(bus.i_src_data);
      n_acc++;
    end
  endtask

  task automatic do_start(input logic [15:0] np);
    bus.i_num_pass = np;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!bus.o_done && c < maxc) begin tick(); c++; end
    chk("done_reached", 32'(bus.o_done), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    chk("rst_done",  32'(bus.o_done), 32'd0);
    chk("rst_err",   32'(bus.o_err), 32'd0);
    chk("rst_k_rd",  32'(bus.o_k_rd), 32'd0);
    chk("rst_ready", 32'(bus.o_src_ready), 32'd0);
    chk("rst_dvi",   32'(bus.o_dp_valid_in), 32'd0);
    chk("rst_kaddr", 32'(bus.o_k_addr), 32'd0);
    chk("rst_pidx",  32'(bus.o_pass_idx), 32'd0);
    chk("rst_pxl",   bus.o_dp_pxl_in, 32'd0);
    chk_k("rst_kbus", bus.o_kernel_bus, '0);
  endtask

  initial begin
    int c;
    bit injd;
    bus.i_start = 1'b0; bus.i_num_pass = '0; bus.i_src_valid = 1'b0;
    bus.i_src_data = '0; bus.i_k_data = '0;
    src_mode = 0; phase = 0;
    clr_counts();

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    tick();

    // two passes, continuous source
    clr_counts();
    src_mode = 1;
    do_start(16'd2);
    chk("start_busy", 32'(bus.o_busy), 32'd1);
    chk("start_krd",  32'(bus.o_k_rd), 32'd1);
    wait_done(3000);
    chk("A_busy_at_done", 32'(bus.o_busy), 32'd0);
    chk("A_err", 32'(bus.o_err), 32'd0);
    chk("A_pass_idx", 32'(bus.o_pass_idx), 32'd1);
    chk("A_n_krd", 32'(n_krd), 32'd34);
    chk("A_n_dvi", 32'(n_dvi), 32'(2 * NPIX));
    chk("A_n_acc", 32'(n_acc), 32'(2 * NPIX));
    chk("A_sb_left", 32'(sbq.size()), 32'd0);
    chk_k("A_kbus_p1", bus.o_kernel_bus, kexp(1));
    tick();
    chk("A_done_pulse", 32'(bus.o_done), 32'd0);
    chk("A_n_done", 32'(n_done), 32'd1);
    chk("A_busy_after", 32'(bus.o_busy), 32'd0);

    // one pass, toggling source
    src_mode = 0; repeat (3) tick();
    clr_counts();
    src_mode = 2;
    do_start(16'd1);
    wait_done(3000);
    chk("B_n_dvi", 32'(n_dvi), 32'(NPIX));
    chk("B_n_acc", 32'(n_acc), 32'(NPIX));
    chk("B_n_krd", 32'(n_krd), 32'(KNUM));
    chk("B_sb_left", 32'(sbq.size()), 32'd0);
    chk("B_err", 32'(bus.o_err), 32'd0);
    chk_k("B_kbus", bus.o_kernel_bus, kexp(0));

    // zero passes
    src_mode = 0; repeat (3) tick();
    clr_counts();
    do_start(16'd0);
    chk("Z_done", 32'(bus.o_done), 32'd1);
    chk("Z_busy", 32'(bus.o_busy), 32'd0);
    tick();
    chk("Z_done_drop", 32'(bus.o_done), 32'd0);
    chk("Z_n_krd", 32'(n_krd), 32'd0);
    chk("Z_saw_busy", 32'(saw_busy), 32'd0);
    chk_k("Z_kbus_hold", bus.o_kernel_bus, kexp(0));

    // spurious output in IDLE, cleared by start, then an extra pulse in a pass
    inj = 1'b1; tick(); inj = 1'b0;
    chk("E_err_idle", 32'(bus.o_err), 32'd1);
    tick();
    clr_counts();
    src_mode = 2;
    do_start(16'd1);
    chk("E_err_clr", 32'(bus.o_err), 32'd0);
    c = 0; injd = 0;
    while (!bus.o_done && c < 3000) begin
      if (!injd && n_dvi > 100 && !dl[LAT-1]) begin inj = 1'b1; injd = 1; end
      else inj = 1'b0;
      tick(); c++;
    end
    inj = 1'b0;
    chk("E_done_reached", 32'(bus.o_done), 32'd1);
    src_mode = 0;
    repeat (LAT + 10) tick();
    chk("E_err_extra", 32'(bus.o_err), 32'd1);

    // reset in the middle of pass 0
    clr_counts();
    src_mode = 1;
    do_start(16'd1);
    c = 0;
    while (n_acc < 100 && c < 1000) begin tick(); c++; end
    chk("R_reached_px100", 32'(n_acc >= 100), 32'd1);
    src_mode = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rst_n = 1'b1;
    clr_counts();
    repeat (3) tick();
    chk("R_idle_err", 32'(bus.o_err), 32'd0);
    chk("R_idle_busy", 32'(bus.o_busy), 32'd0);
    src_mode = 1;
    do_start(16'd1);
    wait_done(3000);
    chk("R_n_krd", 32'(n_krd), 32'(KNUM));
    chk("R_n_dvi", 32'(n_dvi), 32'(NPIX));
    chk("R_err", 32'(bus.o_err), 32'd0);
    chk_k("R_kbus", bus.o_kernel_bus, kexp(0));
    src_mode = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
